// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings and helpers for the hazard controller
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // MEM result is younger than WB, so it wins when both match
  function automatic fwd_sel_e fwd_ex_sel(
    input logic [4:0] src,
    input logic       reg_write_m,
    input logic [4:0] write_reg_m,
    input logic       reg_write_w,
    input logic [4:0] write_reg_w
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (src != 5'd0 && reg_write_m && src == write_reg_m) begin
      sel = FWD_M;
    end else if (src != 5'd0 && reg_write_w && src == write_reg_w) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle of the hazard controller
interface hazard_ctrl_if;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic [4:0]  RsE;
  logic [4:0]  RtE;
  logic [4:0]  WriteRegE;
  logic [4:0]  WriteRegM;
  logic [4:0]  WriteRegW;
  logic        RegWriteE;
  logic        RegWriteM;
  logic        RegWriteW;
  logic        MemtoRegE;
  logic        MemtoRegM;
  logic        BranchD;
  logic        MulDivStartE;
  logic        MulDivOpE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic        ForwardAD;
  logic        ForwardBD;
  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        FlushE;
  logic        FlushM;
  logic        MulDivBusy;
  logic        MulDivDone;
  logic [15:0] StallCount;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD,
    output MulDivStartE, MulDivOpE,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
    input  StallF, StallD, StallE, FlushE, FlushM,
    input  MulDivBusy, MulDivDone, StallCount
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD,
    input  MulDivStartE, MulDivOpE,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
    output StallF, StallD, StallE, FlushE, FlushM,
    output MulDivBusy, MulDivDone, StallCount
  );
endinterface

// File: rtl/hazard_ctrl_muldiv_seq.sv
// rtl/hazard_ctrl_muldiv_seq.sv - multi-cycle EX occupancy sequencer
module muldiv_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_op,
  output logic o_mdstall,
  output logic o_busy,
  output logic o_done
);

  // Counter holds the BUSY cycles still to run, so an op spends N-2 cycles in
  // BUSY after its IDLE start cycle and completes in DONE at cycle N-1.
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

  md_state_e  r_state;
  logic [5:0] r_cnt;
  logic       r_busy;
  logic       r_done;
  logic [5:0] w_load;

  assign w_load = i_op ? DIV_LOAD : MUL_LOAD;

  // State, counter and decoded status flags advance together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= 6'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_cnt  <= w_load;
            r_busy <= 1'b1;
            if (w_load == 6'd0) begin
              r_state <= MD_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_state <= MD_DONE;
            r_done  <= 1'b1;
          end
        end
        MD_DONE: begin
          r_state <= MD_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= MD_IDLE;
          r_cnt   <= 6'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Start in IDLE stalls immediately; a held start in BUSY/DONE is ignored
  always_comb begin
    o_mdstall = (r_state == MD_BUSY) || (r_state == MD_IDLE && i_start);
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, stall and flush control for the 5-stage pipeline
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  logic        w_lwstall;
  logic        w_branchstall;
  logic        w_mdstall;
  logic        w_stall_fd;
  logic        w_e_hit;
  logic        w_m_hit;
  logic [15:0] r_stall_cnt;

  muldiv_seq #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_muldiv_seq (
    .clk      (clk),
    .reset    (reset),
    .i_start  (hz.MulDivStartE),
    .i_op     (hz.MulDivOpE),
    .o_mdstall(w_mdstall),
    .o_busy   (hz.MulDivBusy),
    .o_done   (hz.MulDivDone)
  );

  // Operand forwarding into EX and into the decode branch comparator
  always_comb begin
    hz.ForwardAE = fwd_ex_sel(hz.RsE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
    hz.ForwardBE = fwd_ex_sel(hz.RtE, hz.RegWriteM, hz.WriteRegM, hz.RegWriteW, hz.WriteRegW);
    hz.ForwardAD = (hz.RsD != 5'd0) && hz.RegWriteM && (hz.RsD == hz.WriteRegM);
    hz.ForwardBD = (hz.RtD != 5'd0) && hz.RegWriteM && (hz.RtD == hz.WriteRegM);
  end

  // Load-use and branch-operand hazards detected against D-stage sources
  always_comb begin
    w_lwstall = hz.MemtoRegE && (hz.WriteRegE != 5'd0) &&
                ((hz.RsD == hz.WriteRegE) || (hz.RtD == hz.WriteRegE));
    w_e_hit   = hz.RegWriteE && (hz.WriteRegE != 5'd0) &&
                ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD));
    w_m_hit   = hz.MemtoRegM && (hz.WriteRegM != 5'd0) &&
                ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD));
    w_branchstall = hz.BranchD && (w_e_hit || w_m_hit);
  end

  // EX hold for multi-cycle ops bubbles MEM; no E flush while EX is held
  always_comb begin
    w_stall_fd = w_lwstall || w_branchstall || w_mdstall;
    hz.StallF  = w_stall_fd;
    hz.StallD  = w_stall_fd;
    hz.StallE  = w_mdstall;
    hz.FlushM  = w_mdstall;
    hz.FlushE  = (w_lwstall || w_branchstall) && !w_mdstall;
  end

  // Saturating count of fetch-stall cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall_fd && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign hz.StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  typedef struct {
    bit       rst;
    bit [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    bit       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD;
    bit       start, op;
  } stim_t;

  typedef struct {
    logic [5:0]  fwd;
    logic [4:0]  stall;
    logic [1:0]  md;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk  (clk),
    .reset(rst),
    .hz   (hif)
  );

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_n   = 0;
  int   mon_n    = 0;
  int   last_done_idx = -1;
  logic [15:0] last_cnt;

  // reference state: an accepted op and how many cycles ago it started
  bit m_active = 0;
  int m_rel    = 0;
  int m_len    = 0;
  int m_count  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at item %0d: got %h expected %h", name, mon_n, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd_e(input bit [4:0] src, input stim_t s);
    if (src != 0 && s.RegWriteM && src == s.WriteRegM) return 2'b10;
    if (src != 0 && s.RegWriteW && src == s.WriteRegW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit in_d(input bit [4:0] r, input stim_t s);
    return r != 0 && (r == s.RsD || r == s.RtD);
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit lw, br, md, busy, done, sf;
    @(posedge clk);
    #1;
    rst              = s.rst;
    hif.RsD          = s.RsD;
    hif.RtD          = s.RtD;
    hif.RsE          = s.RsE;
    hif.RtE          = s.RtE;
    hif.WriteRegE    = s.WriteRegE;
    hif.WriteRegM    = s.WriteRegM;
    hif.WriteRegW    = s.WriteRegW;
    hif.RegWriteE    = s.RegWriteE;
    hif.RegWriteM    = s.RegWriteM;
    hif.RegWriteW    = s.RegWriteW;
    hif.MemtoRegE    = s.MemtoRegE;
    hif.MemtoRegM    = s.MemtoRegM;
    hif.BranchD      = s.BranchD;
    hif.MulDivStartE = s.start;
    hif.MulDivOpE    = s.op;
    if (s.rst) begin
      m_active = 0;
      m_count  = 0;
    end
    lw = s.MemtoRegE && in_d(s.WriteRegE, s);
    br = s.BranchD && ((s.RegWriteE && in_d(s.WriteRegE, s)) ||
                       (s.MemtoRegM && in_d(s.WriteRegM, s)));
    if (!m_active) begin
      md = s.start; busy = 0; done = 0;
    end else begin
      md = (m_rel <= m_len - 2); busy = 1; done = (m_rel == m_len - 1);
    end
    sf = lw || br || md;
    e.fwd   = {ref_fwd_e(s.RsE, s), ref_fwd_e(s.RtE, s),
               1'(s.RsD != 0 && s.RegWriteM && s.RsD == s.WriteRegM),
               1'(s.RtD != 0 && s.RegWriteM && s.RtD == s.WriteRegM)};
    e.stall = {sf, sf, md, 1'((lw || br) && !md), md};
    e.md    = {busy, done};
    e.cnt   = 16'(m_count);
    sb_q.push_back(e);
    step_n++;
    if (!s.rst) begin
      if (sf && m_count < 65535) m_count++;
      if (!m_active) begin
        if (s.start) begin
          m_active = 1; m_rel = 1; m_len = s.op ? DIV_N : MUL_N;
        end
      end else if (m_rel == m_len - 1) begin
        m_active = 0;
      end else begin
        m_rel++;
      end
    end
  endtask

  // Monitor: outputs settle every cycle, compare against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("forward", 16'({hif.ForwardAE, hif.ForwardBE, hif.ForwardAD, hif.ForwardBD}), 16'(e.fwd));
      chk("stall_flush", 16'({hif.StallF, hif.StallD, hif.StallE, hif.FlushE, hif.FlushM}), 16'(e.stall));
      chk("muldiv_status", 16'({hif.MulDivBusy, hif.MulDivDone}), 16'(e.md));
      chk("stall_count", hif.StallCount, e.cnt);
      if (hif.MulDivDone === 1'b1) last_done_idx = mon_n;
      last_cnt = hif.StallCount;
      mon_n++;
    end
  end

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst       = ($urandom_range(0, 499) == 0);
    s.RsD       = 5'($urandom_range(0, 3));
    s.RtD       = 5'($urandom_range(0, 3));
    s.RsE       = 5'($urandom_range(0, 3));
    s.RtE       = 5'($urandom_range(0, 3));
    s.WriteRegE = 5'($urandom_range(0, 3));
    s.WriteRegM = 5'($urandom_range(0, 3));
    s.WriteRegW = 5'($urandom_range(0, 3));
    s.RegWriteE = 1'($urandom);
    s.RegWriteM = 1'($urandom);
    s.RegWriteW = 1'($urandom);
    s.MemtoRegE = ($urandom_range(0, 3) == 0);
    s.MemtoRegM = ($urandom_range(0, 3) == 0);
    s.BranchD   = ($urandom_range(0, 3) == 0);
    s.start     = ($urandom_range(0, 7) == 0);
    s.op        = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    int base;
    s = idle_stim();
    s.rst = 1;
    step(s);
    step(s);

    // forwarding priority: M over W, then W alone, then r0 never forwards
    s = idle_stim();
    s.RsE = 5; s.RegWriteM = 1; s.WriteRegM = 5; s.RegWriteW = 1; s.WriteRegW = 5;
    step(s);
    s.RegWriteM = 0;
    step(s);
    s.RsE = 0;
    step(s);

    // load-use stall for one cycle
    s = idle_stim();
    s.MemtoRegE = 1; s.WriteRegE = 7; s.RtD = 7;
    step(s);
    step(idle_stim());

    // multiply: done three cycles after the start cycle
    s = idle_stim();
    s.start = 1;
    base = step_n;
    step(s);
    for (int i = 0; i < MUL_N; i++) step(idle_stim());
    settle();
    chk("mul_done_cycle", 16'(last_done_idx - base), 16'(MUL_N - 1));

    // divide started alongside a load-use stall, start held throughout
    s = idle_stim();
    s.start = 1; s.op = 1; s.MemtoRegE = 1; s.WriteRegE = 7; s.RtD = 7;
    base = step_n;
    for (int i = 0; i < DIV_N; i++) step(s);
    step(idle_stim());
    settle();
    chk("div_done_cycle", 16'(last_done_idx - base), 16'(DIV_N - 1));

    // reset ten cycles into a divide, then a full divide afterwards
    s = idle_stim();
    s.start = 1; s.op = 1;
    step(s);
    for (int i = 0; i < 9; i++) step(idle_stim());
    s = idle_stim();
    s.rst = 1;
    step(s);
    s = idle_stim();
    s.start = 1; s.op = 1;
    base = step_n;
    step(s);
    for (int i = 0; i < DIV_N; i++) step(idle_stim());
    settle();
    chk("div_after_reset", 16'(last_done_idx - base), 16'(DIV_N - 1));

    // randomized traffic
    for (int i = 0; i < 3000; i++) step(rand_stim());

    // long forced stall drives the counter into saturation
    s = idle_stim();
    s.MemtoRegE = 1; s.WriteRegE = 3; s.RsD = 3;
    for (int i = 0; i < 70000; i++) step(s);
    step(idle_stim());
    settle();
    chk("count_saturated", last_cnt, 16'hFFFF);

    chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
